// File: rtl/pixel_stream_rx.sv
// pixel_stream_rx: assembles one serial binary image into a parallel pixel vector.
// Pixels arrive one bit per strobe, pixel 0 first, and are shifted in from the top.
// After N_PIXELS captures, pixel i sits at bit i.
// Optional feature macro: PIX_INPUT_SYNC_EN.
//   Defined: 2-flop synchronisers on all pin inputs, plus rising-edge detection on
//     the strobes (capture latency 2 clocks).
//   Undefined: inputs are used directly. pix_valid qualifies every edge, and
//     frame_start acts as a level restart.
//
// state  | meaning
// S_IDLE | top FSM is not in LOAD_STATE; pixels and pix_count are held
// S_RECV | shifting in pixels of the current frame
// S_DONE | frame complete; load_done high, further strobes flag overrun
module pixel_stream_rx #(
  parameter int         N_PIXELS   = 784,
  parameter int         CNT_W      = 10,
  parameter logic [2:0] LOAD_STATE = 3'd1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [2:0]          state,
  input  logic                pix_valid,
  input  logic                pix_data,
  input  logic                frame_start,
  output logic [N_PIXELS-1:0] pixels,
  output logic                load_done,
  output logic [CNT_W-1:0]    pix_count,
  output logic                overrun
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RECV = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(N_PIXELS);

  logic [1:0]       fsm;
  logic             pv_rise;
  logic             fs_rise;
  logic             pd_cap;
  logic             restart;
  logic             capture;
  logic [CNT_W-1:0] cnt_base;
  logic [CNT_W-1:0] cnt_next;

`ifdef PIX_INPUT_SYNC_EN
  logic [2:0] pv_sync;
  logic [2:0] fs_sync;
  logic [1:0] pd_sync;

  // Two-stage synchronisers; the third stage on each strobe gives a one-clock rise pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv_sync <= '0;
      fs_sync <= '0;
      pd_sync <= '0;
    end else begin
      pv_sync <= {pv_sync[1:0], pix_valid};
      fs_sync <= {fs_sync[1:0], frame_start};
      pd_sync <= {pd_sync[0], pix_data};
    end
  end

  assign pv_rise = pv_sync[1] & ~pv_sync[2];
  assign fs_rise = fs_sync[1] & ~fs_sync[2];
  // Data comes from its own second stage so it lines up with pv_rise.
  assign pd_cap  = pd_sync[1];
`else
  assign pv_rise = pix_valid;
  assign fs_rise = frame_start;
  assign pd_cap  = pix_data;
`endif

  // A restart counts from zero, so a strobe that coincides with it becomes pixel 0
  always_comb begin
    restart  = fs_rise && (fsm != S_IDLE);
    capture  = pv_rise && (restart || (fsm == S_RECV));
    cnt_base = restart ? '0 : pix_count;
    cnt_next = cnt_base + CNT_W'(1);
  end

  // Frame FSM, shift register, counter and status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm       <= S_IDLE;
      pixels    <= '0;
      pix_count <= '0;
      load_done <= 1'b0;
      overrun   <= 1'b0;
    end else if (state != LOAD_STATE) begin
      fsm       <= S_IDLE;
      load_done <= 1'b0;
    end else if (fsm == S_IDLE) begin
      fsm       <= S_RECV;
      pix_count <= '0;
      load_done <= 1'b0;
    end else begin
      if (restart) begin
        overrun <= 1'b0;
      end else if (pv_rise && (fsm == S_DONE)) begin
        overrun <= 1'b1;
      end

      if (capture) begin
        pixels    <= {pd_cap, pixels[N_PIXELS-1:1]};
        pix_count <= cnt_next;
      end else if (restart) begin
        pix_count <= '0;
      end

      if (capture && (cnt_next == CNT_FULL)) begin
        fsm       <= S_DONE;
        load_done <= 1'b1;
      end else if (restart || (fsm == S_RECV)) begin
        fsm       <= S_RECV;
        load_done <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pixel_stream_rx.sv
// Testbench for pixel_stream_rx. The reference model tracks the history of
// captured bits, the frame count and status flags. Each stimulus pushes the
// expected outputs, tagged with the clock edge at which they should appear, and
// an independent monitor compares them.
module tb_pixel_stream_rx;

  localparam int         N    = 784;
  localparam int         CW   = 10;
  localparam logic [2:0] LOAD = 3'd1;
`ifdef PIX_INPUT_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [2:0]    state = 3'd0;
  logic          pix_valid = 1'b0;
  logic          pix_data = 1'b0;
  logic          frame_start = 1'b0;
  logic [N-1:0]  pixels;
  logic          load_done;
  logic [CW-1:0] pix_count;
  logic          overrun;

  pixel_stream_rx #(.N_PIXELS(N), .CNT_W(CW), .LOAD_STATE(LOAD)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .state       (state),
    .pix_valid   (pix_valid),
    .pix_data    (pix_data),
    .frame_start (frame_start),
    .pixels      (pixels),
    .load_done   (load_done),
    .pix_count   (pix_count),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vecs = 0;
  int errs = 0;

  typedef struct {
    int           cyc;
    logic [N-1:0] pix;
    int           cnt;
    int           ld;
    int           ov;
  } exp_t;

  exp_t q[$];

  // Reference model state
  bit hist[$];
  int m_count  = 0;
  bit m_done   = 1'b0;
  bit m_ov     = 1'b0;
  bit m_active = 1'b0;

  task automatic chk_vec(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // The image is simply the last N captured bits, with the newest at the top
  function automatic logic [N-1:0] model_pixels();
    logic [N-1:0] v;
    v = '0;
    for (int m = 0; m < hist.size(); m++) v[N-1-m] = hist[hist.size()-1-m];
    return v;
  endfunction

  task automatic push_exp(input int c);
    exp_t e;
    e.cyc = c;
    e.pix = model_pixels();
    e.cnt = m_count;
    e.ld  = (m_active && m_done) ? 1 : 0;
    e.ov  = m_ov ? 1 : 0;
    q.push_back(e);
  endtask

  task automatic model_event(input bit fs, input bit pv, input bit d);
    if (m_active) begin
      if (fs) begin
        m_count = 0;
        m_ov    = 1'b0;
        m_done  = 1'b0;
      end
      if (pv) begin
        if (!m_done) begin
          hist.push_back(d);
          if (hist.size() > N) void'(hist.pop_front());
          m_count++;
          if (m_count == N) m_done = 1'b1;
        end else begin
          m_ov = 1'b1;
        end
      end
    end
  endtask

  task automatic strobe(input bit fs, input bit pv, input bit d);
`ifdef PIX_INPUT_SYNC_EN
    pix_data = d;
    @(negedge clk);
    pix_valid   = pv;
    frame_start = fs;
    model_event(fs, pv, d);
    push_exp(cyc + 1 + LAT);
    repeat (2) @(negedge clk);
    pix_valid   = 1'b0;
    frame_start = 1'b0;
    @(negedge clk);
`else
    pix_data    = d;
    pix_valid   = pv;
    frame_start = fs;
    model_event(fs, pv, d);
    push_exp(cyc + 1 + LAT);
    @(negedge clk);
    pix_valid   = 1'b0;
    frame_start = 1'b0;
`endif
  endtask

  // mode 0: random data, 1: alternating 1,0,..., 2: all ones
  task automatic send_frame(input int n, input int mode);
    bit d;
    for (int i = 0; i < n; i++) begin
      d = (mode == 0) ? 1'($urandom) : (mode == 1) ? ((i % 2) == 0) : 1'b1;
      strobe(1'b0, 1'b1, d);
    end
  endtask

  task automatic set_load(input bit on);
    state = on ? LOAD : 3'd2;
    if (on) begin
      m_active = 1'b1;
      m_count  = 0;
      m_done   = 1'b0;
    end else begin
      m_active = 1'b0;
    end
    push_exp(cyc + 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic hold_test();
`ifdef PIX_INPUT_SYNC_EN
    int cap;
    bit d;
    d = 1'($urandom);
    pix_data = d;
    @(negedge clk);
    pix_valid = 1'b1;
    cap = cyc + 3;
    push_exp(cap - 1);
    model_event(1'b0, 1'b1, d);
    push_exp(cap);
    push_exp(cap + 8);
    repeat (10) @(negedge clk);
    pix_valid = 1'b0;
    repeat (3) @(negedge clk);
`else
    for (int i = 0; i < 10; i++) begin
      pix_data  = 1'($urandom);
      pix_valid = 1'b1;
      model_event(1'b0, 1'b1, pix_data);
      push_exp(cyc + 1);
      @(negedge clk);
    end
    pix_valid = 1'b0;
`endif
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      vecs++;
      errs++;
      $display("FAIL drain_timeout: %0d expectations pending, required 0", q.size());
      q.delete();
    end
  endtask

  // Monitor: compare DUT outputs against every expectation due at this edge
  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0 && q[0].cyc < cyc) begin
      e = q.pop_front();
      vecs++;
      errs++;
      $display("FAIL sb_missed: expectation for edge %0d not checked, now edge %0d", e.cyc, cyc);
    end
    while (q.size() > 0 && q[0].cyc == cyc) begin
      e = q.pop_front();
      chk_vec("sb_pixels", pixels, e.pix);
      chk_int("sb_pix_count", int'(pix_count), e.cnt);
      chk_int("sb_load_done", int'(load_done), e.ld);
      chk_int("sb_overrun", int'(overrun), e.ov);
    end
  end

  task automatic model_reset();
    hist.delete();
    m_count  = 0;
    m_done   = 1'b0;
    m_ov     = 1'b0;
    m_active = (state == LOAD);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_vec("reset_pixels", pixels, '0);
    chk_int("reset_pix_count", int'(pix_count), 0);
    chk_int("reset_load_done", int'(load_done), 0);
    chk_int("reset_overrun", int'(overrun), 0);

    state = LOAD;
    model_reset();
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Full alternating frame
    send_frame(N, 1);
    drain();
    chk_vec("alt_frame_pixels", pixels, {392{2'b01}});
    chk_int("alt_frame_count", int'(pix_count), N);
    chk_int("alt_frame_done", int'(load_done), 1);

    // Extra strobes after the frame is complete
    send_frame(3, 0);
    drain();
    chk_int("overrun_set", int'(overrun), 1);

    // Restart, partial frame, restart again, then a full frame of ones
    strobe(1'b1, 1'b0, 1'b0);
    send_frame(100, 0);
    strobe(1'b1, 1'b0, 1'b0);
    send_frame(N, 2);
    drain();
    chk_vec("ones_frame_pixels", pixels, '1);
    chk_int("ones_frame_count", int'(pix_count), N);
    strobe(1'b1, 1'b1, 1'b0);
    drain();
    chk_int("coincident_count", int'(pix_count), 1);

    // Abort mid-frame by leaving LOAD_STATE; strobes and restarts are ignored while out
    strobe(1'b1, 1'b0, 1'b0);
    send_frame(300, 0);
    set_load(1'b0);
    strobe(1'b0, 1'b1, 1'b1);
    strobe(1'b1, 1'b0, 1'b0);
    drain();
    chk_int("abort_count_hold", int'(pix_count), 300);
    set_load(1'b1);
    send_frame(N, 0);
    drain();

    // Held strobe
    strobe(1'b1, 1'b0, 1'b0);
    hold_test();
    send_frame(5, 0);
    drain();

    // Asynchronous reset mid-frame
    strobe(1'b1, 1'b0, 1'b0);
    send_frame(500, 0);
    drain();
    #2 rst_n = 1'b0;
    #1;
    chk_vec("async_rst_pixels", pixels, '0);
    chk_int("async_rst_count", int'(pix_count), 0);
    chk_int("async_rst_done", int'(load_done), 0);
    chk_int("async_rst_overrun", int'(overrun), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    send_frame(N, 0);
    drain();
    chk_int("post_rst_count", int'(pix_count), N);
    chk_int("post_rst_done", int'(load_done), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/pixel_stream_rx.md
# pixel_stream_rx

Upstream input stage of the MNIST BNN datapath. It receives one 28×28 binary image as a slow serial pixel stream on dedicated input pins and assembles it into a 784-bit `pixels` vector. It reports `load_done` to the top-level FSM and holds `pixels` stable for layer one. It replaces the bare pixel register with synchronised, strobe-qualified, restartable loading.

## Interface
Parameters:
- `N_PIXELS`, default 784: pixels per frame.
- `CNT_W`, default 10: pixel counter width; must satisfy 2^CNT_W > N_PIXELS.
- `LOAD_STATE`, default 3'd1: FSM `state` encoding that enables loading.

Ports (clock and reset first):
- `clk`  in  1: single clock. One clock; every flop is on `clk` rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `state`  in  3: top FSM state.
- `pix_valid`  in  1: pixel strobe from pin; one rising edge = one pixel.
- `pix_data`  in  1: pixel value, 1 = ink.
- `frame_start`  in  1: restart strobe from pin; rising edge restarts the frame.
- `pixels`  out  N_PIXELS: assembled image; bit i = pixel i (row-major, pixel 0 first received).
- `load_done`  out  1: level; high while a complete frame is held in LOAD_STATE.
- `pix_count`  out  CNT_W: pixels received in the current frame.
- `overrun`  out  1: sticky; a strobe arrived after the frame was complete.

## Operation
- Reset: all outputs and internal flops go to 0 (`pixels`=0, `pix_count`=0, `load_done`=0, `overrun`=0, synchronisers 0). FSM enters IDLE.
- Input conditioning: `pix_valid`, `pix_data` and `frame_start` each pass through a 2-flop synchroniser. A third flop on `pix_valid` and on `frame_start` provides rising-edge detection.
  - `pv_rise` = sync2 & ~sync3 on `pix_valid`.
  - `fs_rise` is formed the same way on `frame_start`.
  - `pix_data` is taken from its own sync2, so it stays aligned with `pv_rise`.
- FSM states: IDLE, RECV, DONE.
  - IDLE → RECV when `state`==LOAD_STATE; `pix_count` is cleared on entry.
  - RECV: on `pv_rise`, `pixels` <= {data, pixels[N-1:1]} and `pix_count`++. After N shifts, pixel 0 sits at bit 0.
  - RECV → DONE on the capture edge that makes `pix_count`==N_PIXELS.
  - DONE: `load_done`=1. `pv_rise` does not shift; it sets `overrun`.
  - Any state → IDLE when `state`!=LOAD_STATE. Then `load_done`=0 and `pix_count` holds its value until the next entry to RECV clears it.
- `pixels` is held unchanged in IDLE and DONE, so downstream layers see a stable image.
- `fs_rise` while in RECV or DONE:
  - clears `pix_count` and `overrun`;
  - forces RECV, which drops `load_done`;
  - leaves `pixels` unchanged (it is overwritten by the new frame).
- `fs_rise` in IDLE is ignored.
- Simultaneous `fs_rise` and `pv_rise`: the restart takes effect, and the same pixel is captured as pixel 0 of the new frame (`pix_count`=1).
- Leaving LOAD_STATE mid-frame aborts the frame. The partial `pixels` are retained and `load_done` stays 0.
- Asynchronous reset mid-frame: immediate return to the reset values above.

## Timing
- With sync (`PIX_INPUT_SYNC_EN` defined):
  - A `pix_valid` rise first sampled at edge k is captured at edge k+2. `pixels` and `pix_count` are visible after edge k+2.
  - `pix_data` must be stable from edge k−1 through k+2.
  - `pix_valid` high time ≥2 cycles; low time ≥2 cycles.
- `load_done` rises at the same edge as the final capture (registered FSM output). It falls on the edge after `state` leaves LOAD_STATE or after `fs_rise`.
- `frame_start` obeys the same 2-cycle latency and minimum pulse width as `pix_valid`.
- Throughput: at most one pixel per 4 clocks with sync; one pixel per clock without.

## Configuration
- `PIX_INPUT_SYNC_EN` defined:
  - synchronisers and edge detection as described;
  - a `pix_valid` held high for many cycles counts as one pixel.
- Not defined:
  - no synchronisers; inputs are used directly;
  - `pix_valid` is a per-cycle qualifier: every edge with `pix_valid`=1 captures `pix_data`;
  - `frame_start` is a level restart, sampled on every edge;
  - capture latency is 0 (the sampling edge itself);
  - intended for simulation and FPGA benches.

## Test plan
- Reset, `state`=LOAD_STATE, 784 strobes with `pix_data` alternating 1,0,... → `pixels` = {392{2'b01}}. `load_done` rises at the final capture edge; `pix_count`=784.
- Complete frame, then 3 extra strobes → `pixels` unchanged, `overrun`=1, `load_done` stays 1.
- 100 pixels, then `fs_rise`, then 784 pixels of all 1s → `pix_count` goes 100→0→784 and `pixels` = all 1s. An `fs_rise` coincident with the first strobe gives `pix_count`=1.
- 300 pixels, then `state` changed away from LOAD_STATE → `load_done`=0, `pix_count` holds 300. Re-entering LOAD_STATE clears `pix_count` and a full frame loads correctly.
- `pix_valid` held high for 10 cycles (sync build) → exactly one capture, at edge k+2. Minimum 2-high/2-low strobes are all captured.
- `rst_n` asserted asynchronously between clock edges at pixel 500 → all outputs are 0 immediately. After release, a fresh 784-pixel frame loads.
